lat_tester_ctrl: RTL and testbench

Latency-tester sequencer that sits directly upstream of the test-pattern video generator and drives its `lt_active`/`lt_mode` inputs. On a trigger it blanks the screen, waits for a dark photosensor reading, then switches on a white box at a vertical-sync boundary. It measures in microseconds the time until the sensor sees light, and reports the result or a timeout.

---
 rtl/lat_tester_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lat_tester_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lat_tester_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lat_tester_ctrl
// Description : Latency-tester sequencer for the test-pattern video generator.
//               On trigger it blanks the screen and waits for a dark sensor
//               reading. It then shows the white box from the next frame
//               start. It measures the time until the photosensor sees light,
//               in microseconds, and reports the result or a timeout.
// Options     : `define LT_SENSOR_DEGLITCH_EN to qualify the synchronized
//               sensor only after DEGLITCH_CYCLES consecutive equal samples.
// Ports       : clk27        27 MHz pixel clock
//               reset        synchronous active-high reset
//               trigger      start request (acted on in IDLE only)
//               lt_mode_sel  requested box position, latched at trigger
//               vsync_in     generator VSYNC, negative polarity
//               sensor_in    photodiode comparator, asynchronous, 1 = light
//               lt_active    test running (to video generator)
//               lt_mode      0 = black, else latched box position
//               busy         controller not idle
//               done         one-cycle pulse at end of every run
//               timeout      sticky error flag of the last run
//               lat_us       latency of the last successful run (us)
// Revision    : 1.0 - initial release
// ============================================================================
module lat_tester_ctrl #(
  parameter int unsigned       CNT_DIV         = 27,
  parameter int unsigned       LAT_W           = 16,
  parameter logic [LAT_W-1:0]  TIMEOUT_US      = LAT_W'(65000),
  parameter int unsigned       DEGLITCH_CYCLES = 8
) (
  input  logic             clk27,
  input  logic             reset,
  input  logic             trigger,
  input  logic [1:0]       lt_mode_sel,
  input  logic             vsync_in,
  input  logic             sensor_in,
  output logic             lt_active,
  output logic [1:0]       lt_mode,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [LAT_W-1:0] lat_us
);

  localparam int unsigned      PRE_W   = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CNT_DIV - 1);

  if (CNT_DIV < 1 || DEGLITCH_CYCLES < 1) begin : g_param_check
    $error("lat_tester_ctrl: CNT_DIV and DEGLITCH_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DARK    = 3'd1,
    ST_WAIT_VS = 3'd2,
    ST_MEASURE = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [LAT_W-1:0] us_q, us_d;
  logic [1:0]       mode_q, mode_d;
  logic             sens_meta_q, sens_sync_q;
  logic             vs_q;
  logic             lt_active_q, lt_active_d;
  logic [1:0]       lt_mode_q, lt_mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [LAT_W-1:0] lat_us_q, lat_us_d;

  logic tick;
  logic vs_fall;
  logic sens_qual;

  assign tick    = (presc_q == PRE_MAX);
  // vs_q resets to 1 so a low VSYNC right after reset is not taken as a frame start.
  assign vs_fall = vs_q & ~vsync_in;

`ifdef LT_SENSOR_DEGLITCH_EN
  localparam int unsigned DG_W = $clog2(DEGLITCH_CYCLES + 1);

  logic [DG_W-1:0] dg_cnt_q;
  logic            qual_q;

  // The qualified level follows sens_sync only after DEGLITCH_CYCLES samples
  // in a row that differ from it. A sample equal to the current level
  // restarts the count.
  always_ff @(posedge clk27) begin
    if (reset) begin
      dg_cnt_q <= '0;
      qual_q   <= 1'b0;
    end else if (sens_sync_q == qual_q) begin
      dg_cnt_q <= '0;
    end else if (dg_cnt_q == DG_W'(DEGLITCH_CYCLES - 1)) begin
      dg_cnt_q <= '0;
      qual_q   <= sens_sync_q;
    end else begin
      dg_cnt_q <= dg_cnt_q + 1'b1;
    end
  end

  assign sens_qual = qual_q;
`else
  assign sens_qual = sens_sync_q;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lat_us_d  = lat_us_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          mode_d    = lt_mode_sel;
          timeout_d = 1'b0;
          state_d   = ST_DARK;
        end
      end
      ST_DARK: begin
        if (!sens_qual)               state_d = ST_WAIT_VS;
        else if (us_q == TIMEOUT_US)  state_d = ST_FAIL;
      end
      ST_WAIT_VS: begin
        if (vs_fall) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        // Light in the same cycle as the timeout is still a valid result.
        if (sens_qual) begin
          lat_us_d = us_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (us_q == TIMEOUT_US) begin
          state_d  = ST_FAIL;
        end
      end
      ST_FAIL: begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Both timebases restart on every state entry. Each state then measures
    // from its own entry. The us counter saturates instead of wrapping.
    if (state_d != state_q) begin
      presc_d = '0;
      us_d    = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      us_d    = (tick && (us_q != TIMEOUT_US)) ? us_q + 1'b1 : us_q;
    end

    // Outputs are registered from the next state, so they change on the
    // same edge as the state itself.
    lt_active_d = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    lt_mode_d   = (state_d == ST_MEASURE) ? mode_d : 2'b00;
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      us_q        <= '0;
      mode_q      <= 2'b00;
      sens_meta_q <= 1'b0;
      sens_sync_q <= 1'b0;
      vs_q        <= 1'b1;
      lt_active_q <= 1'b0;
      lt_mode_q   <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      lat_us_q    <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      us_q        <= us_d;
      mode_q      <= mode_d;
      sens_meta_q <= sensor_in;
      sens_sync_q <= sens_meta_q;
      vs_q        <= vsync_in;
      lt_active_q <= lt_active_d;
      lt_mode_q   <= lt_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      lat_us_q    <= lat_us_d;
    end
  end

  assign lt_active = lt_active_q;
  assign lt_mode   = lt_mode_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign lat_us    = lat_us_q;

endmodule
`default_nettype wire

// File: tb/tb_lat_tester_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lat_tester_ctrl
// Description : Randomized self-checking bench for lat_tester_ctrl. Expected
//               completion cycle, latency and timeout flag are computed
//               arithmetically from the sensor rise time and the MEASURE entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lat_tester_ctrl;

  localparam int CNT_DIV = 27;
  localparam int LAT_W   = 16;
  localparam int TO      = 100;
  localparam int DG      = 8;
`ifdef LT_SENSOR_DEGLITCH_EN
  localparam int XLAT = DG;
`else
  localparam int XLAT = 0;
`endif
  localparam int TO_CYC = CNT_DIV * TO;

  logic             clk27 = 1'b0;
  logic             reset;
  logic             trigger;
  logic [1:0]       lt_mode_sel;
  logic             vsync_in;
  logic             sensor_in;
  logic             lt_active;
  logic [1:0]       lt_mode;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [LAT_W-1:0] lat_us;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_lat  = 0;
  int exp_tmo  = 0;

  always #5 clk27 = ~clk27;

  lat_tester_ctrl #(
    .CNT_DIV         (CNT_DIV),
    .LAT_W           (LAT_W),
    .TIMEOUT_US      (LAT_W'(TO)),
    .DEGLITCH_CYCLES (DG)
  ) u_dut (
    .clk27       (clk27),
    .reset       (reset),
    .trigger     (trigger),
    .lt_mode_sel (lt_mode_sel),
    .vsync_in    (vsync_in),
    .sensor_in   (sensor_in),
    .lt_active   (lt_active),
    .lt_mode     (lt_mode),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .lat_us      (lat_us)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: return 1 time unit after the rising edge, where outputs are
  // sampled and new inputs are driven for the following edge.
  task automatic step();
    @(posedge clk27);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_active"}, lt_active, 0);
    chk({tag, "_mode"},   lt_mode,   0);
    chk({tag, "_busy"},   busy,      0);
    chk({tag, "_done"},   done,      0);
    chk({tag, "_tmo"},    timeout,   0);
    chk({tag, "_lat"},    lat_us,    0);
  endtask

  // One full run with a dark sensor at trigger. The sensor pin rises while
  // the bench is in cycle m+d, m being the first MEASURE cycle. With the
  // glitch set to g >= 0, the pin is high for cycles m+g..m+g+4 only. With the
  // abort set to a >= 0, reset is asserted in cycle m+a.
  task automatic run_meas(input int d, input logic [1:0] sel, input int g, input int a);
    int  m, exp_done, lat_e, bound;
    bit  success;
    lt_mode_sel = sel;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("trig_active", lt_active, 1);
    chk("trig_busy",   busy,      1);
    chk("trig_mode",   lt_mode,   0);
    chk("trig_tmo",    timeout,   0);
    exp_tmo = 0;
    repeat ($urandom_range(3, 12)) begin
      step();
      chk("wait_mode", lt_mode, 0);
    end
    vsync_in = 1'b0;
    step();
    m = cyc;
    chk("meas_mode",   lt_mode,   sel);
    chk("meas_active", lt_active, 1);

    // The sync takes 2 cycles (plus the optional deglitch). The result is
    // captured 1 cycle later. At cycle m+j the counter reads floor(j/CNT_DIV),
    // saturating at TO. From m+TO_CYC the run fails unless light is seen.
    success  = (d + 2 + XLAT) <= TO_CYC;
    lat_e    = (d + 2 + XLAT) / CNT_DIV;
    exp_done = success ? (m + d + 3 + XLAT) : (m + TO_CYC + 2);
    bound    = TO_CYC + 60;

    while (!done && (cyc - m) < bound) begin
      if (a >= 0 && (cyc - m) == a) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        sensor_in = 1'b0;
        vsync_in = 1'b1;
        exp_lat = 0;
        exp_tmo = 0;
        check_reset_outputs("abort");
        repeat (20 + XLAT) step();
        return;
      end
      if (g >= 0 && (cyc - m) == g)     sensor_in = 1'b1;
      if (g >= 0 && (cyc - m) == g + 5) sensor_in = 1'b0;
      if ((cyc - m) == d)               sensor_in = 1'b1;
      if (cyc == m + 1) begin
        trigger     = 1'b1;
        lt_mode_sel = ~sel;
      end
      if (cyc == m + 2) begin
        trigger  = 1'b0;
        vsync_in = 1'b1;
      end
      step();
      if (!done && (success || cyc < exp_done - 1)) chk("run_mode", lt_mode, sel);
    end

    if (success) exp_lat = lat_e;
    exp_tmo = success ? 0 : 1;
    chk("done_cyc",    done ? cyc : -1, exp_done);
    chk("done_lat",    lat_us,  exp_lat);
    chk("done_tmo",    timeout, exp_tmo);
    chk("done_busy",   busy,    0);
    chk("done_active", lt_active, 0);
    step();
    chk("done_pulse",  done, 0);
    chk("idle_lat",    lat_us, exp_lat);
    sensor_in   = 1'b0;
    vsync_in    = 1'b1;
    trigger     = 1'b0;
    lt_mode_sel = 2'($urandom_range(0, 3));
    repeat (20 + XLAT) step();
  endtask

  // Sensor already lit at trigger: the run must stay blanked in DARK and
  // time out TO microseconds after DARK entry, whatever VSYNC does.
  task automatic run_stuck_light();
    int t, exp_done;
    sensor_in = 1'b1;
    repeat (10 + XLAT) step();
    lt_mode_sel = 2'd3;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    t = cyc;
    exp_done = t + TO_CYC + 2;
    while (!done && (cyc - t) < TO_CYC + 60) begin
      vsync_in = (((cyc / 37) % 2) == 0);
      step();
      if (!done) chk("dark_mode", lt_mode, 0);
    end
    exp_tmo = 1;
    chk("dark_done_cyc", done ? cyc : -1, exp_done);
    chk("dark_tmo",      timeout, 1);
    chk("dark_lat",      lat_us,  exp_lat);
    step();
    chk("dark_pulse",    done, 0);
    sensor_in = 1'b0;
    vsync_in  = 1'b1;
    repeat (20 + XLAT) step();
  endtask

  initial begin
    reset       = 1'b1;
    trigger     = 1'b0;
    lt_mode_sel = 2'd0;
    vsync_in    = 1'b1;
    sensor_in   = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (10) step();
    check_reset_outputs("post_rst");

    run_meas(CNT_DIV * 40, 2'd2, -1, -1);
    run_meas(TO_CYC - 2 - XLAT, 2'd1, -1, -1);
    run_meas(TO_CYC - 1 - XLAT, 2'd3, -1, -1);
    run_stuck_light();
    run_meas(0, 2'd2, -1, -1);

    for (int i = 0; i < 10; i++) begin
      run_meas(int'($urandom_range(0, TO_CYC + 50)), 2'($urandom_range(1, 3)), -1, -1);
    end

`ifdef LT_SENSOR_DEGLITCH_EN
    run_meas(CNT_DIV * 20, 2'd1, CNT_DIV * 5, -1);
`endif

    run_meas(TO_CYC + 40, 2'd2, -1, 500);
    run_meas(CNT_DIV * 7 + 3, 2'd1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
